safe_report_tx: RTL and testbench

SAFE_REPORT_TX -- requirements
Module: safe_report_tx

---
 rtl/safe_report_tx_if.sv | 40 ++++
 rtl/safe_report_tx.sv | 273 +++++++++++++++++++++++++++
 tb/tb_safe_report_tx.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/safe_report_tx_if.sv
// -----------------------------------------------------------------------------
// safe_report_tx_if
//   Word-write debug bus used by safe_report_tx to publish safety-latency
//   records and the simulation-halt word.
//
//   Signals:
//     en    master->slave  write request (a write is pending)
//     we    master->slave  write strobe, always equal to en
//     addr  master->slave  24-bit word address
//     data  master->slave  32-bit write data
//     gnt   slave->master  sink accepts the pending write at the rising edge
//                          where en && gnt
//
//   Modports:
//     master  the report transmitter
//     slave   the debug sink
// -----------------------------------------------------------------------------
interface safe_report_tx_if;
  logic        en;
  logic        we;
  logic [23:0] addr;
  logic [31:0] data;
  logic        gnt;

  modport master (
    output en,
    output we,
    output addr,
    output data,
    input  gnt
  );

  modport slave (
    input  en,
    input  we,
    input  addr,
    input  data,
    output gnt
  );
endinterface

// File: rtl/safe_report_tx.sv
// -----------------------------------------------------------------------------
// safe_report_tx
//   Buffers safety-latency records in a small FIFO and serialises each record
//   onto the debug bus as four word writes (send time, inference time,
//   producer/consumer edge, inference latency). A halt request queues one
//   final write of zero to HALT_ADDR, issued only after every buffered or
//   in-flight record has been written; after it is accepted the block goes
//   quiet until reset.
//
//   Parameters:
//     DEPTH      record FIFO depth in entries (2, 4 or 8)
//     HALT_ADDR  debug bus word address of the simulation-halt word
//
//   Ports:
//     clk_i        clock, rising edge
//     rst_ni       asynchronous active-low reset
//     rec_valid_i  record offered on snd_time_i/inf_time_i/prod_i/cons_i/inf_lat_i
//     rec_ready_o  FIFO accepts a record this cycle
//     halt_req_i   single-cycle halt request pulse
//     bus          debug bus, master side (en/we/addr/data out, gnt in)
//     rec_cnt_o    number of fully transmitted records, modulo 2^16
//     halted_o     halt word has been accepted by the sink
// -----------------------------------------------------------------------------
module safe_report_tx #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [23:0] HALT_ADDR = 24'h000004
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rec_valid_i,
  output logic                    rec_ready_o,
  input  logic [31:0]             snd_time_i,
  input  logic [31:0]             inf_time_i,
  input  logic [15:0]             prod_i,
  input  logic [15:0]             cons_i,
  input  logic [31:0]             inf_lat_i,
  input  logic                    halt_req_i,
  safe_report_tx_if.master        bus,
  output logic [15:0]             rec_cnt_o,
  output logic                    halted_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [23:0] ADDR_SND  = 24'h000050;
  localparam logic [23:0] ADDR_INF  = 24'h000054;
  localparam logic [23:0] ADDR_EDGE = 24'h000058;
  localparam logic [23:0] ADDR_LAT  = 24'h00005C;

  typedef struct packed {
    logic [31:0] snd;
    logic [31:0] inf;
    logic [15:0] prod;
    logic [15:0] cons;
    logic [31:0] lat;
  } rec_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SND  = 3'd1,
    ST_INF  = 3'd2,
    ST_EDGE = 3'd3,
    ST_LAT  = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  state_e          state_q,        state_d;
  rec_t            mem_q [DEPTH];
  rec_t            mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q,       wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,       rd_ptr_d;
  logic [CW-1:0]   count_q,        count_d;
  rec_t            work_q,         work_d;
  logic            halt_pending_q, halt_pending_d;
  logic            halted_q,       halted_d;
  logic [15:0]     rec_cnt_q,      rec_cnt_d;
  logic            rec_ready_q,    rec_ready_d;
  logic            en_q,           en_d;
  logic [23:0]     addr_q,         addr_d;
  logic [31:0]     data_q,         data_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  rec_t  rec_in_s;
  logic  push_s;
  logic  pop_s;
  logic  empty_s;
  logic  lat_grant_s;
  logic  halt_grant_s;

  assign rec_in_s = {snd_time_i, inf_time_i, prod_i, cons_i, inf_lat_i};

  // Handshake qualifiers: a pop happens whenever the FSM is free to start the
  // next record (IDLE, or LAT being granted), which lets records stream with
  // no idle cycle in between.
  always_comb begin
    push_s       = rec_valid_i && rec_ready_q;
    empty_s      = (count_q == {CW{1'b0}});
    lat_grant_s  = (state_q == ST_LAT)  && bus.gnt;
    halt_grant_s = (state_q == ST_HALT) && bus.gnt;
    pop_s        = !empty_s && ((state_q == ST_IDLE) || lat_grant_s);
  end

  // FIFO storage, pointers, occupancy and the working register.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_s) begin
      mem_d[wr_ptr_q] = rec_in_s;
      wr_ptr_d        = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      work_d   = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
      work_d   = work_q;
    end
    // Push and pop in the same cycle leave the occupancy unchanged.
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Halt bookkeeping, transmitted-record counter and acceptance flag. The
  // ready flag is registered from next-state values so it is glitch-free.
  always_comb begin
    if (halt_grant_s) begin
      halt_pending_d = 1'b0;
    end else if (halt_req_i && !halted_q) begin
      // A repeated request while already pending just re-sets the same bit.
      halt_pending_d = 1'b1;
    end else begin
      halt_pending_d = halt_pending_q;
    end
    if (halt_grant_s) begin
      halted_d = 1'b1;
    end else begin
      halted_d = halted_q;
    end
    if (lat_grant_s) begin
      rec_cnt_d = rec_cnt_q + 16'd1;
    end else begin
      rec_cnt_d = rec_cnt_q;
    end
    rec_ready_d = (count_d != CW'(DEPTH)) && !halt_pending_d && !halted_d;
  end

  // FSM next-state logic. Records always take priority over the halt word so
  // the halt is written only after the FIFO has fully drained.
  always_comb begin
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          state_d = ST_SND;
        end else if (halt_pending_q) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SND:  state_d = bus.gnt ? ST_INF  : ST_SND;
      ST_INF:  state_d = bus.gnt ? ST_EDGE : ST_INF;
      ST_EDGE: state_d = bus.gnt ? ST_LAT  : ST_EDGE;
      ST_LAT: begin
        if (!bus.gnt) begin
          state_d = ST_LAT;
        end else if (!empty_s) begin
          state_d = ST_SND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: state_d = bus.gnt ? ST_IDLE : ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode from the next state and next working record, so the
  // bus outputs come straight from flops and line up with the state register.
  always_comb begin
    case (state_d)
      ST_SND: begin
        en_d   = 1'b1;
        addr_d = ADDR_SND;
        data_d = work_d.snd;
      end
      ST_INF: begin
        en_d   = 1'b1;
        addr_d = ADDR_INF;
        data_d = work_d.inf;
      end
      ST_EDGE: begin
        en_d   = 1'b1;
        addr_d = ADDR_EDGE;
        data_d = {work_d.prod, work_d.cons};
      end
      ST_LAT: begin
        en_d   = 1'b1;
        addr_d = ADDR_LAT;
        data_d = work_d.lat;
      end
      ST_HALT: begin
        en_d   = 1'b1;
        addr_d = HALT_ADDR;
        data_d = 32'h0000_0000;
      end
      default: begin
        en_d   = 1'b0;
        addr_d = 24'h000000;
        data_d = 32'h0000_0000;
      end
    endcase
  end

  // State and control registers; reset aborts any write and empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= {PW{1'b0}};
      rd_ptr_q       <= {PW{1'b0}};
      count_q        <= {CW{1'b0}};
      work_q         <= '0;
      halt_pending_q <= 1'b0;
      halted_q       <= 1'b0;
      rec_cnt_q      <= 16'd0;
      rec_ready_q    <= 1'b1;
      en_q           <= 1'b0;
      addr_q         <= 24'h000000;
      data_q         <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      work_q         <= work_d;
      halt_pending_q <= halt_pending_d;
      halted_q       <= halted_d;
      rec_cnt_q      <= rec_cnt_d;
      rec_ready_q    <= rec_ready_d;
      en_q           <= en_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
    end
  end

  // FIFO data array; stale entries are harmless because reset clears the
  // pointers and occupancy.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign rec_ready_o = rec_ready_q;
  assign rec_cnt_o   = rec_cnt_q;
  assign halted_o    = halted_q;
  assign bus.en      = en_q;
  assign bus.we      = en_q;
  assign bus.addr    = addr_q;
  assign bus.data    = data_q;

endmodule

// File: tb/tb_safe_report_tx.sv
// -----------------------------------------------------------------------------
// tb_safe_report_tx
//   Self-checking bench for safe_report_tx. A negedge monitor keeps a
//   transaction-level model: every accepted record expands into its four
//   expected bus writes, a halt request appends the halt write, and each
//   granted write is compared in order. Table vectors, hand sequences and a
//   randomized phase drive the stimulus.
// -----------------------------------------------------------------------------
module tb_safe_report_tx;

  localparam logic [23:0] HALT_A = 24'h000004;

  typedef struct packed {
    logic [31:0] snd;
    logic [31:0] inf;
    logic [15:0] prod;
    logic [15:0] cons;
    logic [31:0] lat;
  } rec_t;

  typedef struct packed {
    logic [23:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct packed {
    rec_t        r;
    logic [31:0] d_snd;
    logic [31:0] d_inf;
    logic [31:0] d_edge;
    logic [31:0] d_lat;
    logic [15:0] cnt;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rec_valid_i = 1'b0;
  logic        rec_ready_o;
  logic [31:0] snd_time_i = 32'd0;
  logic [31:0] inf_time_i = 32'd0;
  logic [15:0] prod_i = 16'd0;
  logic [15:0] cons_i = 16'd0;
  logic [31:0] inf_lat_i = 32'd0;
  logic        halt_req_i = 1'b0;
  logic [15:0] rec_cnt_o;
  logic        halted_o;

  safe_report_tx_if bus ();

  safe_report_tx #(.DEPTH(2), .HALT_ADDR(HALT_A)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rec_valid_i (rec_valid_i),
    .rec_ready_o (rec_ready_o),
    .snd_time_i  (snd_time_i),
    .inf_time_i  (inf_time_i),
    .prod_i      (prod_i),
    .cons_i      (cons_i),
    .inf_lat_i   (inf_lat_i),
    .halt_req_i  (halt_req_i),
    .bus         (bus),
    .rec_cnt_o   (rec_cnt_o),
    .halted_o    (halted_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          acc_cnt = 0;
  logic [15:0] done_cnt = 16'd0;
  bit          halt_seen = 1'b0;
  bit          halt_done = 1'b0;
  wr_t         exp_q[$];
  logic        prev_en = 1'b0;
  logic        prev_gnt = 1'b0;
  logic [23:0] prev_addr = 24'h0;
  logic [31:0] prev_data = 32'h0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tmo(input string name, input int budget);
    checks++;
    errors++;
    $display("FAIL %s: no progress within %0d cycles", name, budget);
  endtask

  // Reference model and bus monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_q.delete();
      done_cnt  = 16'd0;
      acc_cnt   = 0;
      halt_seen = 1'b0;
      halt_done = 1'b0;
      prev_en   = 1'b0;
      chk("rst_ready", rec_ready_o, 1);
      chk("rst_en", bus.en, 0);
      chk("rst_we", bus.we, 0);
      chk("rst_addr", bus.addr, 0);
      chk("rst_data", bus.data, 0);
      chk("rst_cnt", rec_cnt_o, 0);
      chk("rst_halted", halted_o, 0);
    end else begin
      chk("we_eq_en", bus.we, bus.en);
      if (!bus.en) begin
        chk("idle_addr_data", {bus.addr, bus.data}, 56'h0);
      end
      if (prev_en && !prev_gnt) begin
        chk("hold_write", {bus.en, bus.addr, bus.data}, {1'b1, prev_addr, prev_data});
      end
      chk("rec_cnt", rec_cnt_o, done_cnt);
      chk("halted", halted_o, halt_done);
      if (bus.en && bus.gnt) begin
        wr_t w;
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %0h/%0h expected none", bus.addr, bus.data);
        end else begin
          w = exp_q.pop_front();
          chk("write", {bus.addr, bus.data}, w);
          if (w.a == 24'h00005C) done_cnt = done_cnt + 16'd1;
          if (w.a == HALT_A) halt_done = 1'b1;
        end
      end
      if (rec_valid_i && rec_ready_o) begin
        acc_cnt++;
        exp_q.push_back({24'h000050, snd_time_i});
        exp_q.push_back({24'h000054, inf_time_i});
        exp_q.push_back({24'h000058, prod_i, cons_i});
        exp_q.push_back({24'h00005C, inf_lat_i});
      end
      if (halt_req_i && !halt_seen) begin
        halt_seen = 1'b1;
        exp_q.push_back({HALT_A, 32'h0});
      end
      prev_en   = bus.en;
      prev_gnt  = bus.gnt;
      prev_addr = bus.addr;
      prev_data = bus.data;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input rec_t r);
    rec_valid_i = 1'b1;
    snd_time_i  = r.snd;
    inf_time_i  = r.inf;
    prod_i      = r.prod;
    cons_i      = r.cons;
    inf_lat_i   = r.lat;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    rec_valid_i = 1'b0;
    halt_req_i  = 1'b0;
    bus.gnt     = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.en) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) tmo(name, budget);
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n = 0;
    while (!halted_o && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) tmo(name, budget);
  endtask

  function automatic rec_t mk_rec(input logic [31:0] s, input logic [31:0] i,
                                  input logic [15:0] p, input logic [15:0] c,
                                  input logic [31:0] l);
    rec_t r;
    r.snd = s; r.inf = i; r.prod = p; r.cons = c; r.lat = l;
    return r;
  endfunction

  function automatic vec_t mk_vec(input rec_t r, input logic [31:0] d0, input logic [31:0] d1,
                                  input logic [31:0] d2, input logic [31:0] d3,
                                  input logic [15:0] cnt);
    vec_t v;
    v.r = r; v.d_snd = d0; v.d_inf = d1; v.d_edge = d2; v.d_lat = d3; v.cnt = cnt;
    return v;
  endfunction

  vec_t        vecs[5];
  logic [23:0] exp_addr[4];
  logic [31:0] exp_data[4];

  initial begin
    int w0;
    int n;
    bus.gnt = 1'b0;

    vecs[0] = mk_vec(mk_rec(32'd100, 32'd250, 16'd3, 16'd7, 32'd150),
                     32'd100, 32'd250, 32'h0003_0007, 32'd150, 16'd1);
    vecs[1] = mk_vec(mk_rec(32'd0, 32'd0, 16'd0, 16'd0, 32'd0),
                     32'd0, 32'd0, 32'h0000_0000, 32'd0, 16'd2);
    vecs[2] = mk_vec(mk_rec(32'hFFFF_FFFF, 32'd1, 16'hFFFF, 16'h0000, 32'h8000_0000),
                     32'hFFFF_FFFF, 32'd1, 32'hFFFF_0000, 32'h8000_0000, 16'd3);
    vecs[3] = mk_vec(mk_rec(32'h1234_5678, 32'h9ABC_DEF0, 16'h1234, 16'hABCD, 32'd5),
                     32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_ABCD, 32'd5, 16'd4);
    vecs[4] = mk_vec(mk_rec(32'hDEAD_BEEF, 32'hCAFE_F00D, 16'h0001, 16'hFFFF, 32'h7FFF_FFFF),
                     32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0001_FFFF, 32'h7FFF_FFFF, 16'd5);
    exp_addr = '{24'h000050, 24'h000054, 24'h000058, 24'h00005C};

    do_reset();

    // Table vectors: single records, gnt held high, exact cycle-by-cycle writes.
    bus.gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_data = '{vecs[k].d_snd, vecs[k].d_inf, vecs[k].d_edge, vecs[k].d_lat};
      drive(vecs[k].r);
      chk("tbl_ready", rec_ready_o, 1);
      step();
      rec_valid_i = 1'b0;
      chk("tbl_e0_no_write", bus.en, 0);
      for (int j = 0; j < 4; j++) begin
        step();
        chk("tbl_en", bus.en, 1);
        chk("tbl_addr", bus.addr, exp_addr[j]);
        chk("tbl_data", bus.data, exp_data[j]);
      end
      step();
      chk("tbl_done_idle", bus.en, 0);
      chk("tbl_cnt", rec_cnt_o, vecs[k].cnt);
    end

    // Back-to-back records stream as 8 consecutive writes.
    drive(mk_rec(32'd11, 32'd12, 16'd13, 16'd14, 32'd15));
    step();
    drive(mk_rec(32'd21, 32'd22, 16'd23, 16'd24, 32'd25));
    step();
    rec_valid_i = 1'b0;
    n = 0;
    while (!bus.en && n < 5) begin step(); n++; end
    n = 0;
    while (bus.en && n < 20) begin step(); n++; end
    chk("b2b_consecutive_writes", n, 8);
    wait_idle("b2b_drain", 20);

    // Stall during the INF write: address and data hold for 5 ungranted cycles.
    drive(mk_rec(32'd500, 32'd250, 16'd1, 16'd2, 32'd3));
    step();
    rec_valid_i = 1'b0;
    n = 0;
    while (bus.addr != 24'h000054 && n < 10) begin step(); n++; end
    if (n >= 10) tmo("stall_find_inf", 10);
    bus.gnt = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk("stall_addr", bus.addr, 24'h000054);
      chk("stall_data", bus.data, 32'd250);
      step();
    end
    bus.gnt = 1'b1;
    step();
    chk("stall_advance", bus.addr, 24'h000058);
    wait_idle("stall_drain", 20);

    // DEPTH=2 fill with gnt low: third record fills the FIFO.
    bus.gnt = 1'b0;
    w0 = wr_cnt;
    drive(mk_rec(32'hA1, 32'hA2, 16'hA3, 16'hA4, 32'hA5));
    chk("fill_ready0", rec_ready_o, 1);
    step();
    drive(mk_rec(32'hB1, 32'hB2, 16'hB3, 16'hB4, 32'hB5));
    chk("fill_ready1", rec_ready_o, 1);
    step();
    drive(mk_rec(32'hC1, 32'hC2, 16'hC3, 16'hC4, 32'hC5));
    chk("fill_ready2", rec_ready_o, 1);
    step();
    rec_valid_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("fill_full", rec_ready_o, 0);
      chk("fill_hold_snd", {bus.addr, bus.data}, {24'h000050, 32'hA1});
      step();
    end
    bus.gnt = 1'b1;
    wait_idle("fill_drain", 40);
    chk("fill_writes", wr_cnt - w0, 12);
    chk("fill_ready_after", rec_ready_o, 1);

    // Halt with two records queued: 8 record writes, then the halt word.
    do_reset();
    w0 = wr_cnt;
    drive(mk_rec(32'd1, 32'd2, 16'd3, 16'd4, 32'd5));
    step();
    drive(mk_rec(32'd6, 32'd7, 16'd8, 16'd9, 32'd10));
    step();
    rec_valid_i = 1'b0;
    halt_req_i  = 1'b1;
    step();
    halt_req_i = 1'b0;
    chk("halt_pending_ready", rec_ready_o, 0);
    bus.gnt = 1'b1;
    wait_halted("halt_wait", 40);
    chk("halt_halted", halted_o, 1);
    chk("halt_writes", wr_cnt - w0, 9);
    drive(mk_rec(32'd77, 32'd77, 16'd77, 16'd77, 32'd77));
    halt_req_i = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("halted_ready", rec_ready_o, 0);
      chk("halted_en", bus.en, 0);
      step();
    end
    rec_valid_i = 1'b0;
    halt_req_i  = 1'b0;
    chk("halted_no_writes", wr_cnt - w0, 9);

    // Record offered in the same cycle as the halt pulse is still accepted.
    do_reset();
    bus.gnt = 1'b1;
    w0 = wr_cnt;
    drive(mk_rec(32'd31, 32'd32, 16'd33, 16'd34, 32'd35));
    halt_req_i = 1'b1;
    chk("same_cycle_ready", rec_ready_o, 1);
    step();
    rec_valid_i = 1'b0;
    halt_req_i  = 1'b0;
    chk("same_cycle_blocked", rec_ready_o, 0);
    wait_halted("same_cycle_halt", 40);
    chk("same_cycle_writes", wr_cnt - w0, 5);
    chk("same_cycle_cnt", rec_cnt_o, 1);

    // Reset asserted during the EDGE write aborts everything at once.
    do_reset();
    bus.gnt = 1'b1;
    drive(mk_rec(32'd41, 32'd42, 16'd43, 16'd44, 32'd45));
    step();
    drive(mk_rec(32'd51, 32'd52, 16'd53, 16'd54, 32'd55));
    step();
    rec_valid_i = 1'b0;
    n = 0;
    while (bus.addr != 24'h000058 && n < 10) begin step(); n++; end
    if (n >= 10) tmo("rst_find_edge", 10);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_en", bus.en, 0);
    chk("midrst_addr", bus.addr, 0);
    step();
    step();
    rst_ni = 1'b1;
    w0 = wr_cnt;
    repeat (10) step();
    chk("midrst_no_writes", wr_cnt - w0, 0);
    chk("midrst_cnt", rec_cnt_o, 0);

    // Randomized traffic with random grants, ending in a halt and drain.
    do_reset();
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        drive(mk_rec($urandom, $urandom, 16'($urandom), 16'($urandom), $urandom));
      end else begin
        rec_valid_i = 1'b0;
      end
      bus.gnt    = ($urandom_range(0, 9) < 7);
      halt_req_i = (it == 250) || (it == 260);
      step();
    end
    rec_valid_i = 1'b0;
    halt_req_i  = 1'b0;
    bus.gnt     = 1'b1;
    wait_halted("rand_halt", 400);
    step();
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_all_sent", done_cnt, 16'(acc_cnt));
    chk("rand_halted", halted_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
